// File: rtl/tdm_pkg.sv
// Shared constants and slot-to-channel mapping for the E1 TDM framer.
package tdm_pkg;

    localparam logic [7:0] TDM_FAS      = 8'h1B;
    localparam logic [7:0] TDM_NFAS     = 8'h40;
    localparam logic [7:0] TDM_MFAS     = 8'h0B;
    localparam logic [7:0] TDM_IDLE     = 8'hFF;
    localparam logic [3:0] TDM_CAS_IDLE = 4'hD;

    // Channel carried by a timeslot; -1 marks an overhead slot (TS0, or the
    // signalling slot while signalling is enabled).
    function automatic int slot_to_ch(input int slot, input int sig_slot, input int sig_en);
        if (slot == 0)
            return -1;
        if (slot < sig_slot)
            return slot - 1;
        if (slot == sig_slot)
            return (sig_en != 0) ? -1 : slot - 1;
        return slot - 1 - sig_en;
    endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Bit/slot/frame position counters with slot-start and pre-slot strobes.
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int N_SLOTS = 32,
    parameter int SLOT_W  = 8,
    parameter int MF_LEN  = 16,
    parameter int BIT_W   = 3,
    parameter int SI_W    = 5,
    parameter int FRM_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [SI_W-1:0]  slot_cnt,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             slot_start,
    output logic             pre_slot,
    output logic             frame_start,
    output logic             mframe_start
);

    logic [BIT_W-1:0] bit_cnt;

    // Counters name the bit emitted on the next ce edge; each wraps into the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            frame_cnt <= '0;
        end else if (ce) begin
            if (bit_cnt == BIT_W'(SLOT_W - 1)) begin
                bit_cnt <= '0;
                if (slot_cnt == SI_W'(N_SLOTS - 1)) begin
                    slot_cnt  <= '0;
                    frame_cnt <= (frame_cnt == FRM_W'(MF_LEN - 1)) ? '0 : frame_cnt + 1'b1;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Strobes are qualified by ce so consumers act on them directly.
    always_comb begin
        slot_start   = ce && (bit_cnt == '0);
        pre_slot     = ce && (bit_cnt == BIT_W'(SLOT_W - 2));
        frame_start  = slot_start && (slot_cnt == '0);
        mframe_start = frame_start && (frame_cnt == '0);
    end

endmodule

// File: rtl/tdm_e1_framer.sv
// E1 TDM framer: TS0 FAS/NFAS, optional MFAS/CAS signalling slot, channel
// payload fetched through a read handshake; serial and slot-parallel outputs.
module tdm_e1_framer
    import tdm_pkg::*;
#(
    parameter int N_SLOTS  = 32,
    parameter int SLOT_W   = 8,
    parameter int SIG_EN   = 1,
    parameter int SIG_SLOT = 16,
    parameter int MF_LEN   = 16,
    parameter logic [SLOT_W-1:0] FAS_WORD  = SLOT_W'(TDM_FAS),
    parameter logic [SLOT_W-1:0] NFAS_WORD = SLOT_W'(TDM_NFAS),
    parameter logic [SLOT_W-1:0] MFAS_WORD = SLOT_W'(TDM_MFAS),
    parameter logic [SLOT_W-1:0] IDLE_WORD = SLOT_W'(TDM_IDLE),
    parameter logic [3:0]        CAS_IDLE  = TDM_CAS_IDLE,
    localparam int N_CH = N_SLOTS - 1 - SIG_EN,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int SI_W = $clog2(N_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              rai,
    input  logic              mf_rai,
    input  logic [4*N_CH-1:0] cas_in,
    output logic              rd_en,
    output logic [CH_W-1:0]   rd_ch,
    input  logic [SLOT_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              ser_out,
    output logic [SLOT_W-1:0] par_out,
    output logic              par_valid,
    output logic [SI_W-1:0]   slot_idx,
    output logic              frame_sync,
    output logic              mframe_sync,
    output logic              underrun
);

    localparam int BIT_W = $clog2(SLOT_W);
    localparam int FRM_W = (MF_LEN > 1) ? $clog2(MF_LEN) : 1;

    logic [SI_W-1:0]   slot_cnt;
    logic [FRM_W-1:0]  frame_cnt;
    logic              slot_start, pre_slot, frame_start, mframe_start;

    logic [SLOT_W-1:0] sh;
    logic [SLOT_W-1:0] stg_data;
    logic              stg_ok;

    logic [SLOT_W-1:0] nfas_w, mfas_w, cas_w, word;
    logic [3:0]        cas_a, cas_b;
    logic              word_ur, req;
    int                fr, next_slot, next_ch;

    tdm_slot_timer #(
        .N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .MF_LEN(MF_LEN),
        .BIT_W(BIT_W), .SI_W(SI_W), .FRM_W(FRM_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .slot_cnt    (slot_cnt),
        .frame_cnt   (frame_cnt),
        .slot_start  (slot_start),
        .pre_slot    (pre_slot),
        .frame_start (frame_start),
        .mframe_start(mframe_start)
    );

    // Overhead words: alarm bits are patched into the fixed patterns.
    assign nfas_w = (NFAS_WORD & ~(SLOT_W'(1) << 5)) | (SLOT_W'(rai) << 5);
    assign mfas_w = (MFAS_WORD & ~(SLOT_W'(1) << 2)) | (SLOT_W'(mf_rai) << 2);
    assign cas_w  = SLOT_W'({cas_a, cas_b});

    // CAS nibbles for frame k: channels k-1 and k-1+MF_LEN-1, idle if absent.
    always_comb begin
        fr    = int'(frame_cnt);
        cas_a = CAS_IDLE;
        cas_b = CAS_IDLE;
        for (int c = 0; c < N_CH; c++) begin
            if (c == fr - 1)          cas_a = cas_in[4*c +: 4];
            if (c == fr + MF_LEN - 2) cas_b = cas_in[4*c +: 4];
        end
    end

    // Word for the slot starting now; payload falls back to idle on underrun.
    always_comb begin
        word    = IDLE_WORD;
        word_ur = 1'b0;
        if (slot_cnt == '0) begin
            word = frame_cnt[0] ? nfas_w : FAS_WORD;
        end else if ((SIG_EN != 0) && (slot_cnt == SI_W'(SIG_SLOT))) begin
            word = (frame_cnt == '0) ? mfas_w : cas_w;
        end else begin
            word    = stg_ok ? stg_data : IDLE_WORD;
            word_ur = !stg_ok;
        end
    end

    // Fetch for the following slot only when it carries a channel.
    always_comb begin
        next_slot = (int'(slot_cnt) == N_SLOTS - 1) ? 0 : int'(slot_cnt) + 1;
        next_ch   = slot_to_ch(next_slot, SIG_SLOT, SIG_EN);
        req       = pre_slot && (next_ch >= 0);
    end

    // Output/shift pipeline; pulses last one clk, data is captured the clk after rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_out     <= 1'b0;
            par_out     <= '0;
            par_valid   <= 1'b0;
            slot_idx    <= '0;
            frame_sync  <= 1'b0;
            mframe_sync <= 1'b0;
            underrun    <= 1'b0;
            rd_en       <= 1'b0;
            rd_ch       <= '0;
            sh          <= '0;
            stg_data    <= '0;
            stg_ok      <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            par_valid   <= 1'b0;
            frame_sync  <= 1'b0;
            mframe_sync <= 1'b0;
            underrun    <= 1'b0;
            if (rd_en) begin
                stg_data <= rd_data;
                stg_ok   <= rd_valid;
            end
            if (ce) begin
                if (slot_start) begin
                    par_out     <= word;
                    sh          <= word << 1;
                    ser_out     <= word[SLOT_W-1];
                    par_valid   <= 1'b1;
                    slot_idx    <= slot_cnt;
                    frame_sync  <= frame_start;
                    mframe_sync <= mframe_start;
                    underrun    <= word_ur;
                end else begin
                    ser_out <= sh[SLOT_W-1];
                    sh      <= sh << 1;
                end
                if (req) begin
                    rd_en <= 1'b1;
                    rd_ch <= CH_W'(next_ch);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_e1_framer.sv
// Bench for tdm_e1_framer: default E1 instance plus an 8-slot no-signalling instance.
module tb_tdm_e1_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ce, rai, mf_rai;

    // default instance: 32 slots, TS16 signalling, 30 channels
    logic [119:0] cas0;
    logic         rd_en0, rd_valid0, ser0, pv0, fs0, mfs0, ur0;
    logic [4:0]   rd_ch0, sidx0;
    logic [7:0]   rd_data0, par0;
    logic [7:0]   src0 [32];
    logic         drop0 [32];

    // small instance: 8 slots, no signalling, 7 channels
    logic [27:0]  cas1;
    logic         rd_en1, rd_valid1, ser1, pv1, fs1, mfs1, ur1;
    logic [2:0]   rd_ch1, sidx1;
    logic [7:0]   rd_data1, par1;
    logic [7:0]   src1 [8];

    assign rd_data0  = src0[rd_ch0];
    assign rd_valid0 = ~drop0[rd_ch0];
    assign rd_data1  = src1[rd_ch1];
    assign rd_valid1 = 1'b1;

    tdm_e1_framer u0 (
        .clk(clk), .rst(rst), .ce(ce), .rai(rai), .mf_rai(mf_rai), .cas_in(cas0),
        .rd_en(rd_en0), .rd_ch(rd_ch0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .ser_out(ser0), .par_out(par0), .par_valid(pv0), .slot_idx(sidx0),
        .frame_sync(fs0), .mframe_sync(mfs0), .underrun(ur0)
    );

    tdm_e1_framer #(.N_SLOTS(8), .SLOT_W(8), .SIG_EN(0), .SIG_SLOT(4)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .rai(rai), .mf_rai(mf_rai), .cas_in(cas1),
        .rd_en(rd_en1), .rd_ch(rd_ch1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .ser_out(ser1), .par_out(par1), .par_valid(pv1), .slot_idx(sidx1),
        .frame_sync(fs1), .mframe_sync(mfs1), .underrun(ur1)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;   // ce edges since reset
    int cur   = 0;   // stream position of the latest ce edge
    bit hit;

    // reference expectations
    logic       e_ser, e_pv, e_fs, e_mfs, e_ur, e_rden;
    logic [7:0] e_par;
    int         e_rdch, e_slot;

    // ---------------- reference model (stream position -> line content) ----
    function automatic logic [3:0] nib(input int c);
        return (c < 30) ? cas0[4*c +: 4] : 4'hD;
    endfunction

    function automatic int ch_of(input int s);
        if (s == 0 || s == 16) return -1;
        return (s < 16) ? s - 1 : s - 2;
    endfunction

    function automatic logic [7:0] word0(input int s, input int f);
        int ch;
        if (s == 0)  return (f % 2 == 1) ? {2'b01, rai, 5'b0} : 8'h1B;
        if (s == 16) return (f == 0) ? {5'b00001, mf_rai, 2'b11} : {nib(f - 1), nib(f + 14)};
        ch = ch_of(s);
        return drop0[ch] ? 8'hFF : src0[ch];
    endfunction

    task automatic model0(input int m);
        int b, s, f, ns;
        b = m % 8; s = (m / 8) % 32; f = (m / 256) % 16; ns = (s + 1) % 32;
        e_par  = word0(s, f);
        e_ser  = e_par[7 - b];
        e_pv   = (b == 0);
        e_fs   = (b == 0) && (s == 0);
        e_mfs  = e_fs && (f == 0);
        e_ur   = (b == 0) && (ch_of(s) >= 0) && drop0[ch_of(s) < 0 ? 0 : ch_of(s)];
        e_rden = (b == 6) && (ch_of(ns) >= 0);
        e_rdch = ch_of(ns);
        e_slot = s;
    endtask

    task automatic model1(input int m);
        int b, s, f, ns;
        b = m % 8; s = (m / 8) % 8; f = (m / 64) % 16; ns = (s + 1) % 8;
        if (s == 0) e_par = (f % 2 == 1) ? {2'b01, rai, 5'b0} : 8'h1B;
        else        e_par = src1[s - 1];
        e_ser  = e_par[7 - b];
        e_pv   = (b == 0);
        e_fs   = (b == 0) && (s == 0);
        e_mfs  = e_fs && (f == 0);
        e_ur   = 1'b0;
        e_rden = (b == 6) && (ns != 0);
        e_rdch = ns - 1;
        e_slot = s;
    endtask

    // ---------------- stimulus plumbing ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            n = 0; hit = 0;
        end else if (ce) begin
            cur = n; n++; hit = 1;
        end else begin
            hit = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_src(input bit seq);
        for (int c = 0; c < 32; c++) begin
            src0[c]  = seq ? 8'(8'hA0 + c) : 8'($urandom);
            drop0[c] = 1'b0;
        end
        for (int c = 0; c < 8; c++) src1[c] = 8'($urandom);
    endtask

    // ---------------- tests -----------------------------------------------
    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        tick(); tick();
        total++; if ({ser0, pv0, fs0, mfs0, ur0, rd_en0} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {ser0, pv0, fs0, mfs0, ur0, rd_en0}); end
        total++; if (par0 !== 8'h00) begin bad++; $display("FAIL reset_par got=%h exp=00", par0); end
        total++; if (sidx0 !== 5'd0) begin bad++; $display("FAIL reset_slot_idx got=%0d exp=0", sidx0); end
        total++; if ({ser1, pv1, fs1, mfs1, ur1, rd_en1, par1, sidx1} !== 17'b0) begin bad++; $display("FAIL reset_small got=%h exp=0", {ser1, pv1, fs1, mfs1, ur1, rd_en1, par1, sidx1}); end
        rst = 1'b0;
    endtask

    task automatic test_fas_stream();
        logic [7:0] first;
        int nfs = 0, nmfs = 0, last_fs = -1;
        fill_src(0); rai = 1'b0; mf_rai = 1'b0; cas0 = '0;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            tick(); model0(cur);
            if (cur < 8) first[7 - cur] = ser0;
            if (fs0) begin
                total++; if (last_fs >= 0 && cur - last_fs != 256) begin bad++; $display("FAIL fs_period got=%0d exp=256", cur - last_fs); end
                last_fs = cur; nfs++;
            end
            if (mfs0) nmfs++;
            total++; if (ser0 !== e_ser) begin bad++; $display("FAIL fas_ser n=%0d got=%b exp=%b", cur, ser0, e_ser); end
            total++; if ({pv0, fs0, mfs0} !== {e_pv, e_fs, e_mfs}) begin bad++; $display("FAIL fas_pulses n=%0d got=%b exp=%b", cur, {pv0, fs0, mfs0}, {e_pv, e_fs, e_mfs}); end
            total++; if (par0 !== e_par || sidx0 !== 5'(e_slot)) begin bad++; $display("FAIL fas_par n=%0d got=%h/%0d exp=%h/%0d", cur, par0, sidx0, e_par, e_slot); end
            if (cur == 256) begin
                total++; if (par0 !== 8'h40) begin bad++; $display("FAIL nfas_word got=%h exp=40", par0); end
            end
        end
        total++; if (first !== 8'b00011011) begin bad++; $display("FAIL fas_first_bits got=%b exp=00011011", first); end
        total++; if (nfs != 2) begin bad++; $display("FAIL fs_count got=%0d exp=2", nfs); end
        total++; if (nmfs != 1) begin bad++; $display("FAIL mfs_count got=%0d exp=1", nmfs); end
    endtask

    task automatic test_payload();
        fill_src(1); rai = 1'b0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tick(); model0(cur);
            total++; if (rd_en0 !== e_rden) begin bad++; $display("FAIL rd_en n=%0d got=%b exp=%b", cur, rd_en0, e_rden); end
            if (e_rden) begin
                total++; if (rd_ch0 !== 5'(e_rdch)) begin bad++; $display("FAIL rd_ch n=%0d got=%0d exp=%0d", cur, rd_ch0, e_rdch); end
            end
            total++; if (par0 !== e_par || ur0 !== 1'b0) begin bad++; $display("FAIL pay_par n=%0d got=%h/%b exp=%h/0", cur, par0, ur0, e_par); end
            if (cur == 40) begin
                total++; if (par0 !== 8'hA4) begin bad++; $display("FAIL ts5 got=%h exp=a4", par0); end
            end
            if (cur == 136) begin
                total++; if (par0 !== 8'hAF) begin bad++; $display("FAIL ts17 got=%h exp=af", par0); end
            end
            if (cur == 38) begin
                total++; if (rd_en0 !== 1'b1 || rd_ch0 !== 5'd4) begin bad++; $display("FAIL rd_ch4 got=%b/%0d exp=1/4", rd_en0, rd_ch0); end
            end
        end
        // random payload with the remote alarm raised
        fill_src(0); rai = 1'b1;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            tick(); model0(cur);
            total++; if (ser0 !== e_ser || par0 !== e_par) begin bad++; $display("FAIL rnd_pay n=%0d got=%b/%h exp=%b/%h", cur, ser0, par0, e_ser, e_par); end
        end
        rai = 1'b0;
    endtask

    task automatic test_underrun();
        int nur = 0;
        fill_src(0); drop0[7] = 1'b1;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tick(); model0(cur);
            if (ur0) nur++;
            total++; if (ur0 !== e_ur || par0 !== e_par) begin bad++; $display("FAIL ur_slot n=%0d got=%b/%h exp=%b/%h", cur, ur0, par0, e_ur, e_par); end
            if (cur == 64) begin
                total++; if ({par0, ur0, pv0} !== {8'hFF, 2'b11}) begin bad++; $display("FAIL ts8_idle got=%h/%b/%b exp=ff/1/1", par0, ur0, pv0); end
            end
        end
        total++; if (nur != 1) begin bad++; $display("FAIL ur_count got=%0d exp=1", nur); end
        // random drop pattern
        for (int c = 0; c < 32; c++) drop0[c] = ($urandom_range(0, 3) == 0);
        do_reset();
        for (int i = 0; i < 512; i++) begin
            tick(); model0(cur);
            total++; if (ur0 !== e_ur || par0 !== e_par || ser0 !== e_ser) begin bad++; $display("FAIL ur_rnd n=%0d got=%b/%h exp=%b/%h", cur, ur0, par0, e_ur, e_par); end
        end
    endtask

    task automatic test_cas();
        int nmfs = 0, last_mfs = -1;
        fill_src(0);
        for (int c = 0; c < 30; c++) cas0[4*c +: 4] = 4'($urandom);
        cas0[3:0] = 4'h1; cas0[63:60] = 4'h2; mf_rai = 1'b1;
        do_reset();
        for (int i = 0; i < 4097; i++) begin
            tick(); model0(cur);
            if (mfs0) begin
                if (last_mfs >= 0) begin
                    total++; if (cur - last_mfs != 4096) begin bad++; $display("FAIL mfs_period got=%0d exp=4096", cur - last_mfs); end
                end
                last_mfs = cur; nmfs++;
            end
            if (e_pv && e_slot == 16) begin
                total++; if (par0 !== e_par) begin bad++; $display("FAIL cas_word n=%0d got=%h exp=%h", cur, par0, e_par); end
            end
            total++; if (ser0 !== e_ser) begin bad++; $display("FAIL cas_ser n=%0d got=%b exp=%b", cur, ser0, e_ser); end
            if (cur == 128) begin
                total++; if (par0 !== 8'h0F) begin bad++; $display("FAIL mfas got=%h exp=0f", par0); end
            end
            if (cur == 384) begin
                total++; if (par0 !== 8'h12) begin bad++; $display("FAIL cas_f1 got=%h exp=12", par0); end
            end
        end
        total++; if (nmfs != 2) begin bad++; $display("FAIL mfs_count got=%0d exp=2", nmfs); end
        mf_rai = 1'b0;
    endtask

    task automatic test_small_cfg();
        int nfs = 0;
        fill_src(0); rai = 1'b0; cas1 = 28'($urandom);
        do_reset();
        for (int i = 0; i < 192; i++) begin
            tick(); model1(cur);
            if (fs1) nfs++;
            total++; if (ser1 !== e_ser || par1 !== e_par || sidx1 !== 3'(e_slot)) begin bad++; $display("FAIL small_word n=%0d got=%b/%h/%0d exp=%b/%h/%0d", cur, ser1, par1, sidx1, e_ser, e_par, e_slot); end
            total++; if ({pv1, fs1, mfs1, ur1} !== {e_pv, e_fs, e_mfs, e_ur}) begin bad++; $display("FAIL small_pulses n=%0d got=%b exp=%b", cur, {pv1, fs1, mfs1, ur1}, {e_pv, e_fs, e_mfs, e_ur}); end
            total++; if (rd_en1 !== e_rden || (e_rden && rd_ch1 !== 3'(e_rdch))) begin bad++; $display("FAIL small_rd n=%0d got=%b/%0d exp=%b/%0d", cur, rd_en1, rd_ch1, e_rden, e_rdch); end
        end
        total++; if (nfs != 3) begin bad++; $display("FAIL small_fs_count got=%0d exp=3", nfs); end
    endtask

    task automatic test_ce_gate_reset();
        bit done = 0;
        fill_src(0); rai = 1'b0;
        do_reset();
        for (int i = 0; i < 400 && !done; i++) begin
            ce = (i % 2 == 0);
            tick(); model0(cur);
            total++; if (ser0 !== e_ser || par0 !== e_par || sidx0 !== 5'(e_slot)) begin bad++; $display("FAIL gate_hold n=%0d ce=%b got=%b/%h/%0d exp=%b/%h/%0d", cur, hit, ser0, par0, sidx0, e_ser, e_par, e_slot); end
            if (!hit) begin
                total++; if (rd_en0 !== 1'b0) begin bad++; $display("FAIL gate_rd_en got=%b exp=0", rd_en0); end
            end
            if (hit && cur == 99) done = 1;
        end
        total++; if (!done) begin bad++; $display("FAIL gate_reach got=%0d exp=99", cur); end
        rst = 1'b1; ce = 1'b1;
        tick();
        total++; if ({ser0, pv0, fs0, mfs0, ur0, rd_en0, par0, sidx0} !== 19'b0) begin bad++; $display("FAIL midreset got=%h exp=0", {ser0, pv0, fs0, mfs0, ur0, rd_en0, par0, sidx0}); end
        rst = 1'b0;
        tick();
        total++; if ({ser0, par0, pv0, fs0, mfs0, sidx0} !== {1'b0, 8'h1B, 3'b111, 5'd0}) begin bad++; $display("FAIL restart got=%b/%h/%b/%b/%b/%0d exp=0/1b/1/1/1/0", ser0, par0, pv0, fs0, mfs0, sidx0); end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; rai = 1'b0; mf_rai = 1'b0; cas0 = '0; cas1 = '0;
        fill_src(0);
        test_reset();
        test_fas_stream();
        test_payload();
        test_underrun();
        test_cas();
        test_small_cfg();
        test_ce_gate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdm_e1_framer.md
Name: tdm_e1_framer

Overview:
- Parametrised successor to the E1 byte multiplexer. Builds complete TDM frames: TS0 alternates FAS/NFAS, TS16 carries MFAS/CAS over a 16-frame multiframe (or is payload when signalling is disabled), and all other slots carry channel bytes.
- Channel bytes are fetched from the channel generators through a read handshake.
- Emits both a serial bit stream (MSB first) and a slot-aligned parallel byte.
- Sits between the channel generators and the line coder.

Parameters:
- N_SLOTS, 32: timeslots per frame; must be at least 3.
- SLOT_W, 8: bits per slot; must be at least 2.
- SIG_EN, 1: 1 = SIG_SLOT carries MFAS/CAS; 0 = SIG_SLOT is a payload slot.
- SIG_SLOT, 16: signalling slot index; must satisfy 1 ≤ SIG_SLOT < N_SLOTS.
- MF_LEN, 16: frames per multiframe.
- FAS_WORD, 8'h1B: TS0 content in even frames.
- NFAS_WORD, 8'h40: TS0 content in odd frames, with the A bit (bit5) forced to 0.
- MFAS_WORD, 8'h0B: SIG_SLOT content in frame 0, with the Y bit (bit2) forced to 0.
- IDLE_WORD, 8'hFF: substituted for a channel byte on underrun.
- CAS_IDLE, 4'hD: ABCD nibble used for nonexistent channels.
- Derived, not overridable: N_CH = N_SLOTS-1-SIG_EN.

Ports:
- clk, in, 1: bit-rate clock.
- rst, in, 1: synchronous, active-high reset.
- ce, in, 1: bit enable; one bit advances per clk with ce=1.
- rai, in, 1: remote alarm; drives NFAS bit5.
- mf_rai, in, 1: multiframe remote alarm; drives MFAS bit2.
- cas_in, in, 4*N_CH: ABCD per channel; channel c occupies bits [4c+3:4c].
- rd_en, out, 1: request for a channel byte.
- rd_ch, out, $clog2(N_CH): index of the requested channel.
- rd_data, in, SLOT_W: requested byte.
- rd_valid, in, 1: qualifies rd_data.
- ser_out, out, 1: serial TDM stream.
- par_out, out, SLOT_W: word currently being serialised.
- par_valid, out, 1: one-cycle pulse at each slot start.
- slot_idx, out, $clog2(N_SLOTS): slot currently being serialised.
- frame_sync, out, 1: pulse at TS0 of every frame.
- mframe_sync, out, 1: pulse at TS0 of frame 0 of the multiframe.
- underrun, out, 1: pulse when IDLE_WORD is substituted.

Behaviour:
- Counters:
  - bit_cnt runs 0..SLOT_W-1.
  - slot_cnt runs 0..N_SLOTS-1.
  - frame_cnt runs 0..MF_LEN-1.
  - All counters advance only on ce and wrap to 0.
  - ce=0: all state and outputs hold, and rd_en=0.
- Reset (rst wins over ce):
  - Counters are 0.
  - ser_out, par_out, par_valid, rd_en, frame_sync, mframe_sync and underrun are 0.
  - slot_idx is 0.
  - Mid-frame reset abandons the current frame; no partial slot completes.
- First ce after reset:
  - ser_out=FAS_WORD[MSB], par_out=FAS_WORD, par_valid=1, frame_sync=1, mframe_sync=1.
- Slot start (first ce of each slot), all at the same edge:
  - par_out is loaded with the slot word.
  - par_valid, and frame_sync/mframe_sync when applicable, pulse for one clk.
  - slot_idx is updated.
  - ser_out carries bit SLOT_W-1; subsequent ce edges shift toward bit 0.
- Slot word selection:
  - TS0, frame_cnt even: FAS_WORD.
  - TS0, frame_cnt odd: NFAS_WORD with bit5=rai.
  - SIG_SLOT with SIG_EN=1, frame 0: MFAS_WORD with bit2=mf_rai.
  - SIG_SLOT with SIG_EN=1, frame k≥1: {ABCD(ch k-1), ABCD(ch k-1+MF_LEN-1)}.
  - In the CAS word, a channel index ≥ N_CH gives CAS_IDLE.
  - cas_in is sampled at that slot start.
  - Any other slot: channel byte.
- Channel mapping (0-based):
  - Slots 1..SIG_SLOT-1 map to ch slot-1.
  - Slots above SIG_SLOT map to ch slot-1-SIG_EN.
  - With SIG_EN=0, SIG_SLOT maps to ch SIG_SLOT-1.
- Read handshake:
  - rd_en pulses for one clk on the ce with bit_cnt==SLOT_W-2, only when the next slot is a payload slot.
  - rd_ch is valid with rd_en.
  - rd_data/rd_valid are sampled exactly one clk after rd_en and staged until the next slot start.
  - rd_valid=0 at sampling: the slot carries IDLE_WORD, and underrun pulses with that slot's par_valid.
  - A request issued at slot N_SLOTS-1 fetches nothing, since TS0 is internal.
- Simultaneous events:
  - rai, mf_rai and cas_in changes take effect only at the next load of TS0 or SIG_SLOT.
  - rst asserted together with rd_valid discards the data.

Decomposition:
- Package tdm_pkg holds:
  - the default FAS/NFAS/MFAS/IDLE constants;
  - CAS_IDLE;
  - a function mapping slot to channel index.
- One sub-module, tdm_slot_timer, holds the bit/slot/frame counters and emits slot_start, pre_slot (bit SLOT_W-2) and frame/mframe pulses.

Test Plan:
- Reset, then ce held at 1 for 2 frames with rai=0 → ser_out begins 0,0,0,1,1,0,1,1; TS0 of frame 1 = 8'h40; frame_sync every 256 ce; mframe_sync once.
- Source returns 8'hA0+ch with rd_valid=1 → TS5=8'hA4 and TS17=8'hAF; rd_ch=4 pulses at bit 6 of TS4.
- rd_valid=0 for ch 7 only → TS8=8'hFF, underrun pulses once aligned with TS8 par_valid; all other slots are correct.
- cas_in sets ch0=4'h1 and ch15=4'h2, and mf_rai=1 → frame 0 TS16=8'h0F; frame 1 TS16=8'h12; mframe_sync period = 4096 ce.
- SIG_EN=0, N_SLOTS=8, SLOT_W=8 → TS16 logic is absent; 7 payload channels 0..6; frame length 64 ce; no CAS words.
- ce toggling 1-0-1, plus rst asserted at slot 12 bit 3 → outputs freeze while ce=0; after rst, the next ce restarts at FAS with frame_sync=1.
